// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-resolve signal bundle between the pipeline and branch_predictor.
// master = pipeline side, slave = predictor side.
interface branch_predictor_if #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] if_pc;
  logic                  pred_taken;
  logic [INDEX_BITS-1:0] pred_idx;
  logic                  ex_valid;
  logic [ADDR_WIDTH-1:0] ex_pc;
  logic [INDEX_BITS-1:0] ex_idx;
  logic                  ex_pred_taken;
  logic                  ex_taken;
  logic [ADDR_WIDTH-1:0] ex_target;
  logic                  rst_out;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [31:0]           mispred_count;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_idx, ex_pred_taken, ex_taken, ex_target,
    input  pred_taken, pred_idx, rst_out, redirect_pc, mispred_count
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_idx, ex_pred_taken, ex_taken, ex_target,
    output pred_taken, pred_idx, rst_out, redirect_pc, mispred_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal 2-bit saturating-counter branch predictor with registered mispredict flush.
// Define BP_GSHARE_EN to XOR the lookup index with a global history register (gshare).
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_BF,
  branch_predictor_if.slave  bus
);
  localparam int ENTRIES = 2 ** INDEX_BITS;

  logic [1:0]            pht [ENTRIES];
  logic [INDEX_BITS-1:0] pc_idx;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic                  flush_q;
  logic [ADDR_WIDTH-1:0] redirect_q;
  logic [31:0]           count_q;
  logic                  accept;
  logic                  mispredict;
  logic [1:0]            cur_ctr;
  logic [1:0]            nxt_ctr;
  logic                  unused_pc_bits;

  assign pc_idx         = bus.if_pc[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{bus.if_pc[ADDR_WIDTH-1:INDEX_BITS+2], bus.if_pc[1:0]};

  // A resolve arriving during a flush cycle is on the wrong path and is dropped entirely.
  assign accept     = bus.ex_valid & ~flush_q;
  assign mispredict = accept & (bus.ex_taken != bus.ex_pred_taken);

`ifdef BP_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr;

  assign lookup_idx = pc_idx ^ ghr;

  always_ff @(posedge clk or posedge rst_BF) begin
    if (rst_BF) begin
      ghr <= '0;
    end else if (accept) begin
      ghr <= {ghr[INDEX_BITS-2:0], bus.ex_taken};
    end
  end
`else
  assign lookup_idx = pc_idx;
`endif

  // Lookup reads the current table contents, so a same-cycle update is seen only next cycle.
  assign bus.pred_idx      = lookup_idx;
  assign bus.pred_taken    = pht[lookup_idx][1];
  assign bus.rst_out       = flush_q;
  assign bus.redirect_pc   = redirect_q;
  assign bus.mispred_count = count_q;

  assign cur_ctr = pht[bus.ex_idx];

  always_comb begin
    nxt_ctr = cur_ctr;
    if (bus.ex_taken) begin
      if (cur_ctr != 2'b11) nxt_ctr = cur_ctr + 2'b01;
    end else begin
      if (cur_ctr != 2'b00) nxt_ctr = cur_ctr - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst_BF) begin
    if (rst_BF) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= 2'b01;
    end else if (accept) begin
      pht[bus.ex_idx] <= nxt_ctr;
    end
  end

  // Flush pulse lasts one cycle; the redirect target is captured alongside and then held.
  always_ff @(posedge clk or posedge rst_BF) begin
    if (rst_BF) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      flush_q <= mispredict;
      if (mispredict) begin
        redirect_q <= bus.ex_taken ? bus.ex_target : bus.ex_pc + ADDR_WIDTH'(4);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_BF) begin
    if (rst_BF) begin
      count_q <= '0;
    end else if (flush_q && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor; a small reference model supplies table expectations.
// Build with BP_GSHARE_EN defined to also exercise the gshare history path.
module tb_branch_predictor;
  localparam int IB = 6;
  localparam int AW = 32;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst_BF;
  exp_t sb[$];
  int   tests_run;
  int   tests_failed;

  logic [1:0]    mpht [2**IB];
  logic [IB-1:0] mghr;
  logic          s3_out [11];

  branch_predictor_if #(.INDEX_BITS(IB), .ADDR_WIDTH(AW)) bus ();

  branch_predictor #(.INDEX_BITS(IB), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .rst_BF (rst_BF),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_output(input logic [31:0] obs);
    exp_t e;
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $error("[TB] FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        tests_failed++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2**IB; i++) mpht[i] = 2'b01;
    mghr = '0;
  endtask

  // Reference counter and history behaviour for an accepted resolve.
  task automatic model_update(input logic [IB-1:0] idx, input logic taken);
    if (taken) begin
      if (mpht[idx] != 2'b11) mpht[idx] = mpht[idx] + 2'b01;
    end else begin
      if (mpht[idx] != 2'b00) mpht[idx] = mpht[idx] - 2'b01;
    end
`ifdef BP_GSHARE_EN
    mghr = {mghr[IB-2:0], taken};
`endif
  endtask

  task automatic apply_stimulus(input logic [IB-1:0] idx, input logic taken, input logic pred,
                                input logic [AW-1:0] pc, input logic [AW-1:0] target);
    bus.ex_valid      = 1'b1;
    bus.ex_idx        = idx;
    bus.ex_taken      = taken;
    bus.ex_pred_taken = pred;
    bus.ex_pc         = pc;
    bus.ex_target     = target;
  endtask

  task automatic idle();
    bus.ex_valid = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive a fetch PC that maps onto table entry k and compare the lookup against the model.
  task automatic probe(input string tag, input logic [IB-1:0] k);
    logic [IB-1:0] raw;
    raw = k ^ mghr;
    bus.if_pc = AW'({raw, 2'b00});
    #1;
    push_exp({tag, "_idx"}, 32'(k));
    push_exp({tag, "_taken"}, 32'(mpht[k][1]));
    check_output(32'(bus.pred_idx));
    check_output(32'(bus.pred_taken));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    s3_out = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    model_reset();
    bus.if_pc = '0;
    bus.ex_valid = 1'b0;
    bus.ex_pc = '0;
    bus.ex_idx = '0;
    bus.ex_pred_taken = 1'b0;
    bus.ex_taken = 1'b0;
    bus.ex_target = '0;
    rst_BF = 1'b1;

    #1;
    push_exp("reset_rst_out", 32'd0);
    push_exp("reset_redirect", 32'd0);
    push_exp("reset_count", 32'd0);
    check_output(32'(bus.rst_out));
    check_output(bus.redirect_pc);
    check_output(bus.mispred_count);

    @(negedge clk);
    rst_BF = 1'b0;

    bus.if_pc = 32'h100;
    #1;
    push_exp("s1_idx", 32'h00);
    push_exp("s1_taken", 32'd0);
    check_output(32'(bus.pred_idx));
    check_output(32'(bus.pred_taken));

    for (int n = 1; n <= 2; n++) begin
      apply_stimulus(6'h00, 1'b1, 1'b0, 32'h100, 32'h400);
      model_update(6'h00, 1'b1);
      cycle();
      push_exp("s2_flush", 32'd1);
      push_exp("s2_redirect", 32'h400);
      push_exp("s2_count_during", 32'(n - 1));
      check_output(32'(bus.rst_out));
      check_output(bus.redirect_pc);
      check_output(bus.mispred_count);
      @(negedge clk);
      idle();
      cycle();
      push_exp("s2_flush_end", 32'd0);
      push_exp("s2_redirect_hold", 32'h400);
      push_exp("s2_count_after", 32'(n));
      check_output(32'(bus.rst_out));
      check_output(bus.redirect_pc);
      check_output(bus.mispred_count);
      @(negedge clk);
    end
    probe("s2_entry0", 6'h00);

    for (int n = 0; n < 11; n++) begin
      apply_stimulus(6'h03, s3_out[n], s3_out[n], 32'h00C, 32'h040);
      model_update(6'h03, s3_out[n]);
      cycle();
      push_exp("s3_no_flush", 32'd0);
      check_output(32'(bus.rst_out));
      @(negedge clk);
      idle();
      probe("s3_entry3", 6'h03);
    end

    @(negedge clk);
    apply_stimulus(6'h00, 1'b0, 1'b1, 32'h200, 32'h999);
    model_update(6'h00, 1'b0);
    cycle();
    push_exp("s4_flush", 32'd1);
    push_exp("s4_redirect", 32'h204);
    check_output(32'(bus.rst_out));
    check_output(bus.redirect_pc);
    @(negedge clk);
    apply_stimulus(6'h07, 1'b1, 1'b0, 32'h300, 32'h800);
    cycle();
    push_exp("s4_second_ignored", 32'd0);
    push_exp("s4_redirect_hold", 32'h204);
    push_exp("s4_count", 32'd3);
    check_output(32'(bus.rst_out));
    check_output(bus.redirect_pc);
    check_output(bus.mispred_count);
    @(negedge clk);
    idle();
    probe("s4_entry7_untouched", 6'h07);

    @(negedge clk);
    bus.if_pc = AW'({6'h05 ^ mghr, 2'b00});
    apply_stimulus(6'h05, 1'b1, 1'b1, 32'h014, 32'h080);
    #1;
    push_exp("s5_idx", 32'h05);
    push_exp("s5_taken_before", 32'd0);
    check_output(32'(bus.pred_idx));
    check_output(32'(bus.pred_taken));
    model_update(6'h05, 1'b1);
    cycle();
    push_exp("s5_taken_after", 32'(mpht[bus.if_pc[IB+1:2] ^ mghr][1]));
    push_exp("s5_no_flush", 32'd0);
    check_output(32'(bus.pred_taken));
    check_output(32'(bus.rst_out));

    @(negedge clk);
    apply_stimulus(6'h01, 1'b1, 1'b0, 32'h004, 32'h0C0);
    cycle();
    push_exp("midflush_rst_out", 32'd1);
    push_exp("midflush_count", 32'd3);
    check_output(32'(bus.rst_out));
    check_output(bus.mispred_count);
    #2;
    rst_BF = 1'b1;
    idle();
    model_reset();
    #1;
    push_exp("midflush_rst_drop", 32'd0);
    push_exp("midflush_count_clr", 32'd0);
    push_exp("midflush_redirect_clr", 32'd0);
    check_output(32'(bus.rst_out));
    check_output(bus.mispred_count);
    check_output(bus.redirect_pc);
    @(negedge clk);
    rst_BF = 1'b0;
    cycle();
    push_exp("midflush_count_lost", 32'd0);
    check_output(bus.mispred_count);
    @(negedge clk);
    probe("reset_entry0", 6'h00);

`ifdef BP_GSHARE_EN
    apply_stimulus(6'h10, 1'b1, 1'b1, 32'h000, 32'h000);
    model_update(6'h10, 1'b1);
    cycle();
    @(negedge clk);
    apply_stimulus(6'h11, 1'b0, 1'b0, 32'h000, 32'h000);
    model_update(6'h11, 1'b0);
    cycle();
    @(negedge clk);
    apply_stimulus(6'h12, 1'b1, 1'b1, 32'h000, 32'h000);
    model_update(6'h12, 1'b1);
    cycle();
    @(negedge clk);
    idle();
    bus.if_pc = 32'h100;
    #1;
    push_exp("s6_gshare_idx", 32'h05);
    check_output(32'(bus.pred_idx));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter INDEX_BITS, default 6, giving log2 of the pattern-table entry count (64 entries).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, giving the PC width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_BF, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port if_pc, input, ADDR_WIDTH bits: PC of the instruction in fetch.
REQ-006 The block SHALL have port pred_taken, output, 1 bit: taken prediction for if_pc.
REQ-007 The block SHALL have port pred_idx, output, INDEX_BITS bits: table index used for if_pc, which the pipeline carries to execute.
REQ-008 The block SHALL have port ex_valid, input, 1 bit: a conditional branch resolves this cycle.
REQ-009 The block SHALL have port ex_pc, input, ADDR_WIDTH bits: PC of the resolving branch.
REQ-010 The block SHALL have port ex_idx, input, INDEX_BITS bits: pred_idx carried with the branch.
REQ-011 The block SHALL have port ex_pred_taken, input, 1 bit: prediction carried with the branch.
REQ-012 The block SHALL have port ex_taken, input, 1 bit: actual branch outcome.
REQ-013 The block SHALL have port ex_target, input, ADDR_WIDTH bits: resolved taken target.
REQ-014 The block SHALL have port rst_out, output, 1 bit: registered mispredict flush pulse to the pipeline.
REQ-015 The block SHALL have port redirect_pc, output, ADDR_WIDTH bits: fetch restart PC, valid while rst_out=1.
REQ-016 The block SHALL have port mispred_count, output, 32 bits: number of rst_out pulses since reset.

Function
REQ-017 The pattern table SHALL hold 2**INDEX_BITS 2-bit saturating counters; 00/01 predict not-taken and 10/11 predict taken.
REQ-018 Lookup SHALL be combinational: pred_idx = if_pc[INDEX_BITS+1:2], and pred_taken = MSB of the entry at pred_idx.
REQ-019 An accepted resolve (ex_valid=1 and rst_out=0) SHALL update entry ex_idx at the clock edge: +1 if ex_taken, saturating at 11; -1 otherwise, saturating at 00.
REQ-020 ex_valid while rst_out=1 SHALL be ignored as wrong-path: no table update, no flush, no count.
REQ-021 A lookup and an update to the same index in one cycle SHALL return the pre-update value (read-before-write).
REQ-022 An accepted resolve with ex_taken != ex_pred_taken SHALL assert rst_out for exactly the next cycle.
REQ-023 During that flush cycle, redirect_pc SHALL be the registered value ex_target if ex_taken=1, else ex_pc+4 modulo 2**ADDR_WIDTH.
REQ-024 Consequently, rst_out SHALL never be high on two consecutive cycles.
REQ-025 mispred_count SHALL increment by 1 on each cycle rst_out=1 and saturate at 32'hFFFFFFFF.
REQ-026 While rst_out=0, redirect_pc SHALL hold its last value.

Reset
REQ-027 rst_BF=1 SHALL immediately force every table entry to 01, rst_out to 0, redirect_pc to 0, mispred_count to 0, and GHR to 0.
REQ-028 Reset asserted mid-flush SHALL drop rst_out within the same cycle, and the pending count increment SHALL be lost.
REQ-029 The first accepted resolve SHALL occur on the first rising edge after rst_BF deasserts.

Configuration
REQ-030 With macro BP_GSHARE_EN defined, the block SHALL keep an INDEX_BITS-wide global history register (GHR) and use pred_idx = if_pc[INDEX_BITS+1:2] XOR GHR.
REQ-031 With BP_GSHARE_EN defined, each accepted resolve SHALL shift the GHR left and insert ex_taken at bit 0; a lookup in the same cycle SHALL use the old GHR.
REQ-032 Without BP_GSHARE_EN, the GHR SHALL be absent and the bimodal indexing of REQ-018 SHALL apply; all ports SHALL be identical in both builds.

Verification
REQ-033 Scenario 1: after reset, if_pc=0x100 -> pred_taken=0 and pred_idx=0x00.
REQ-034 Scenario 2: two accepted resolves with ex_idx=0x00, ex_taken=1, ex_pred_taken=0 -> rst_out pulses after each, mispred_count=2, entry 0x00 becomes 11, and pred_taken=1 for if_pc=0x100.
REQ-035 Scenario 3: five taken resolves to one index, then one not-taken -> entry goes 11 then 10, pred_taken stays 1, and no flush occurs when ex_pred_taken=1 on the taken resolves.
REQ-036 Scenario 4: a mispredict at ex_pc=0x200 with ex_taken=0, followed next cycle by a second mispredicting resolve -> one rst_out pulse, redirect_pc=0x204, and the second resolve is ignored with mispred_count incrementing by 1.
REQ-037 Scenario 5: lookup and update to index 0x05 in the same cycle from state 01 with ex_taken=1 -> pred_taken=0 that cycle and 1 the next.
REQ-038 Scenario 6: with BP_GSHARE_EN defined, after resolves with outcomes 1,0,1 -> GHR=0b000101, and if_pc=0x100 gives pred_idx=0x05.
